// File: rtl/alu_bist.sv
// -----------------------------------------------------------------------------
// alu_bist
// Built-in self-test initiator for the RV32I ALU. On a start pulse it walks
// opcodes 0000..1001 in ascending order, applying VECTORS_PER_OP vectors to
// each (a fixed corner vector first, then LFSR-generated vectors). It
// captures the ALU result and Zero flag and checks them against an internal
// golden model. It reports pass/fail, a saturating mismatch count, and the
// opcode and vector index of the first mismatch.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_start             start pulse, honoured only in IDLE or DONE
//   o_operand_a/_b      ALU operands (registered)
//   o_alu_op            ALU opcode (registered)
//   i_alu_data, i_zero  ALU result and Zero flag
//   o_busy              high in APPLY/COMPARE
//   o_done              high in DONE
//   o_pass              valid in DONE; 1 = no mismatch seen
//   o_fail_count        mismatching vectors, saturating at 16'hFFFF
//   o_first_fail_op     opcode of the first mismatch
//   o_first_fail_vec    vector index (within its opcode) of the first mismatch
// -----------------------------------------------------------------------------
module alu_bist #(
  parameter int unsigned VECTORS_PER_OP = 10,
  parameter logic [31:0] SEED           = 32'hACE1_2345
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [31:0] o_operand_a,
  output logic [31:0] o_operand_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_data,
  input  logic        i_zero,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_fail_count,
  output logic [3:0]  o_first_fail_op,
  output logic [15:0] o_first_fail_vec
);

  typedef enum logic [1:0] {IDLE, APPLY, COMPARE, DONE} state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [15:0] VEC_LAST  = 16'(VECTORS_PER_OP - 1);
  localparam logic [3:0]  OP_LAST   = 4'd9;

  // Galois LFSR, right shift; taps are applied when the shifted-out bit is 1.
  function automatic logic [31:0] step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == 4'd5) || (op == 4'd6) || (op == 4'd9);
  endfunction

  function automatic logic [31:0] golden(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = {31'h0, (a < b)};
      4'd8: r = {31'h0, ($signed(a) < $signed(b))};
      4'd9: r = $unsigned($signed(a) >>> b[4:0]);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  state_t      state, state_next;
  logic [31:0] lfsr;
  logic [15:0] vec_idx;
  logic [31:0] cap_data;
  logic        cap_zero;

  // Load-path signals: the vector that is presented on the next APPLY.
  logic        start_load;
  logic        end_of_op;
  logic        last_vec;
  logic [3:0]  load_op;
  logic [15:0] load_vec;
  logic [31:0] lfsr_base;
  logic [31:0] rand_b;
  logic [31:0] load_a;
  logic [31:0] load_b;
  logic [31:0] load_lfsr;

  // Compare-path signals.
  logic [31:0] exp_data;
  logic        mismatch;
  logic [15:0] fail_next;

  assign o_busy = (state == APPLY) || (state == COMPARE);
  assign o_done = (state == DONE);

  assign start_load = ((state == IDLE) || (state == DONE)) && i_start;
  assign end_of_op  = (vec_idx == VEC_LAST);
  assign last_vec   = end_of_op && (o_alu_op == OP_LAST);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = APPLY;
      APPLY:   state_next = COMPARE;
      COMPARE: state_next = last_vec ? DONE : APPLY;
      DONE:    if (i_start) state_next = APPLY;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-vector generation. A start loads vector 0 of op 0000 from SEED;
  // otherwise the vector after the current one is derived from the live LFSR.
  // Corner vectors leave the LFSR untouched; random vectors consume two steps.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_op   = o_alu_op;
    load_vec  = vec_idx + 16'd1;
    lfsr_base = lfsr;
    if (start_load) begin
      load_op   = 4'd0;
      load_vec  = 16'd0;
      lfsr_base = SEED;
    end else if (end_of_op) begin
      load_op  = o_alu_op + 4'd1;
      load_vec = 16'd0;
    end

    rand_b = step(lfsr_base);
    if (load_vec == 16'd0) begin
      load_a    = 32'h8000_0000;
      load_b    = is_shift(load_op) ? 32'h0000_001F : 32'h0000_0001;
      load_lfsr = lfsr_base;
    end else begin
      load_a    = lfsr_base;
      load_b    = is_shift(load_op) ? (rand_b & 32'h0000_001F) : rand_b;
      load_lfsr = step(rand_b);
    end
  end

  // ---------------------------------------------------------------------------
  // Golden-model comparison against the values captured during APPLY.
  // ---------------------------------------------------------------------------
  always_comb begin
    exp_data  = golden(o_alu_op, o_operand_a, o_operand_b);
    mismatch  = (cap_data != exp_data) || (cap_zero != (exp_data == 32'h0));
    fail_next = o_fail_count;
    if (mismatch && (o_fail_count != 16'hFFFF)) fail_next = o_fail_count + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr             <= 32'h0;
      vec_idx          <= 16'd0;
      o_operand_a      <= 32'h0;
      o_operand_b      <= 32'h0;
      o_alu_op         <= 4'd0;
      cap_data         <= 32'h0;
      cap_zero         <= 1'b0;
      o_pass           <= 1'b0;
      o_fail_count     <= 16'd0;
      o_first_fail_op  <= 4'd0;
      o_first_fail_vec <= 16'd0;
    end else if (start_load) begin
      o_pass           <= 1'b0;
      o_fail_count     <= 16'd0;
      o_first_fail_op  <= 4'd0;
      o_first_fail_vec <= 16'd0;
      o_alu_op         <= load_op;
      vec_idx          <= load_vec;
      o_operand_a      <= load_a;
      o_operand_b      <= load_b;
      lfsr             <= load_lfsr;
    end else if (state == APPLY) begin
      cap_data <= i_alu_data;
      cap_zero <= i_zero;
    end else if (state == COMPARE) begin
      o_fail_count <= fail_next;
      // The count never returns to zero within a run, so zero marks "no
      // mismatch recorded yet".
      if (mismatch && (o_fail_count == 16'd0)) begin
        o_first_fail_op  <= o_alu_op;
        o_first_fail_vec <= vec_idx;
      end
      if (last_vec) begin
        o_pass <= (fail_next == 16'd0);
      end else begin
        o_alu_op    <= load_op;
        vec_idx     <= load_vec;
        o_operand_a <= load_a;
        o_operand_b <= load_b;
        lfsr        <= load_lfsr;
      end
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// -----------------------------------------------------------------------------
// tb_alu_bist
// Directed bench for alu_bist. Two instances are used: one with the default
// VECTORS_PER_OP (10) and one with VECTORS_PER_OP = 1. A behavioural ALU sits
// on each instance's operand bus; alu_mode selects a correct ALU, an ALU
// whose sra behaves as srl, or an ALU whose Zero flag is stuck at 0.
// -----------------------------------------------------------------------------
module tb_alu_bist;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start1;
  int          alu_mode;
  int          checks;
  int          failures;

  // Default instance (V = 10)
  logic [31:0] op_a, op_b, alu_data;
  logic [3:0]  alu_op;
  logic        zero, busy, done, pass;
  logic [15:0] fail_count, first_fail_vec;
  logic [3:0]  first_fail_op;

  // V = 1 instance
  logic [31:0] op_a1, op_b1, alu_data1;
  logic [3:0]  alu_op1;
  logic        zero1, busy1, done1, pass1;
  logic [15:0] fail_count1, first_fail_vec1;
  logic [3:0]  first_fail_op1;

  alu_bist dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .o_operand_a      (op_a),
    .o_operand_b      (op_b),
    .o_alu_op         (alu_op),
    .i_alu_data       (alu_data),
    .i_zero           (zero),
    .o_busy           (busy),
    .o_done           (done),
    .o_pass           (pass),
    .o_fail_count     (fail_count),
    .o_first_fail_op  (first_fail_op),
    .o_first_fail_vec (first_fail_vec)
  );

  alu_bist #(.VECTORS_PER_OP(1)) dut1 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start1),
    .o_operand_a      (op_a1),
    .o_operand_b      (op_b1),
    .o_alu_op         (alu_op1),
    .i_alu_data       (alu_data1),
    .i_zero           (zero1),
    .o_busy           (busy1),
    .o_done           (done1),
    .o_pass           (pass1),
    .o_fail_count     (fail_count1),
    .o_first_fail_op  (first_fail_op1),
    .o_first_fail_vec (first_fail_vec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real one; returns {zero, data}.
  function automatic logic [32:0] alu_model(input int mode, input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        z;
    r = 32'h0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = (a < b) ? 32'h1 : 32'h0;
      4'd8: r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      4'd9: r = (mode == 1) ? (a >> b[4:0]) : $unsigned($signed(a) >>> b[4:0]);
      default: r = 32'h0;
    endcase
    z = (mode == 2) ? 1'b0 : (r == 32'h0);
    return {z, r};
  endfunction

  always_comb {zero, alu_data}   = alu_model(alu_mode, alu_op, op_a, op_b);
  always_comb {zero1, alu_data1} = alu_model(alu_mode, alu_op1, op_a1, op_b1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance n rising edges and return at the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Start a run on the default instance, check the first two vectors, and
  // wait (bounded) for done. cycles = edges after the start edge. A second
  // start pulse is injected at cycle repulse_at (negative = none).
  task automatic run_main(input string tag, input int repulse_at);
    int cycles;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cycles = 0;
    check({tag, "_busy"}, {31'h0, busy}, 32'h1);
    check({tag, "_vec0_a"}, op_a, 32'h8000_0000);
    check({tag, "_vec0_b"}, op_b, 32'h0000_0001);
    tick(2);
    cycles = 2;
    check({tag, "_vec1_op"}, {28'h0, alu_op}, 32'h0);
    check({tag, "_vec1_a"}, op_a, 32'hACE1_2345);
    check({tag, "_vec1_b"}, op_b, 32'hD650_91A1);
    while (!done && cycles < 1000) begin
      if (cycles == repulse_at) start = 1'b1;
      tick(1);
      start = 1'b0;
      cycles++;
    end
    check({tag, "_done_latency"}, cycles, 32'd200);
    check({tag, "_busy_in_done"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    alu_mode = 0;
    rst      = 1'b1;
    start    = 1'b0;
    start1   = 1'b0;
    @(negedge clk);
    tick(2);
    rst = 1'b0;

    // Reset state
    check("rst_a", op_a, 32'h0);
    check("rst_b", op_b, 32'h0);
    check("rst_op", {28'h0, alu_op}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_pass", {31'h0, pass}, 32'h0);
    check("rst_fcnt", {16'h0, fail_count}, 32'h0);

    // 1: correct ALU, full run passes
    run_main("t1", -1);
    check("t1_pass", {31'h0, pass}, 32'h1);
    check("t1_fcnt", {16'h0, fail_count}, 32'h0);
    tick(3);
    check("t1_hold_done", {31'h0, done}, 32'h1);
    check("t1_hold_pass", {31'h0, pass}, 32'h1);

    // 2: sra behaves as srl; restart straight from DONE
    alu_mode = 1;
    run_main("t2", -1);
    check("t2_pass", {31'h0, pass}, 32'h0);
    check("t2_first_op", {28'h0, first_fail_op}, 32'h9);
    check("t2_first_vec", {16'h0, first_fail_vec}, 32'h0);
    check("t2_fcnt_nonzero", {31'h0, (fail_count != 16'd0)}, 32'h1);

    // 3: Zero stuck at 0; corner vectors of and/sll/sltu expect zero=1
    alu_mode = 2;
    run_main("t3", -1);
    check("t3_pass", {31'h0, pass}, 32'h0);
    check("t3_first_op", {28'h0, first_fail_op}, 32'h2);
    check("t3_first_vec", {16'h0, first_fail_vec}, 32'h0);
    check("t3_fcnt_ge3", {31'h0, (fail_count >= 16'd3)}, 32'h1);

    // 5: start re-pulsed mid-run is ignored; results cleared by restart
    alu_mode = 0;
    run_main("t5a", 50);
    check("t5a_pass", {31'h0, pass}, 32'h1);
    check("t5a_fcnt", {16'h0, fail_count}, 32'h0);
    check("t5a_first_op", {28'h0, first_fail_op}, 32'h0);
    run_main("t5b", -1);
    check("t5b_pass", {31'h0, pass}, 32'h1);

    // 6: reset together with start at cycle 77 aborts the run
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(77);
    rst   = 1'b1;
    start = 1'b1;
    tick(1);
    rst   = 1'b0;
    start = 1'b0;
    check("t6_busy", {31'h0, busy}, 32'h0);
    check("t6_done", {31'h0, done}, 32'h0);
    check("t6_a", op_a, 32'h0);
    check("t6_b", op_b, 32'h0);
    check("t6_op", {28'h0, alu_op}, 32'h0);
    check("t6_fcnt", {16'h0, fail_count}, 32'h0);
    tick(4);
    check("t6_idle_busy", {31'h0, busy}, 32'h0);
    run_main("t6r", -1);
    check("t6r_pass", {31'h0, pass}, 32'h1);

    // 4: V = 1 instance walks opcodes 0..9, two cycles each, corner operands
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("t4_op_c%0d", k), {28'h0, alu_op1}, 32'(k / 2));
      check($sformatf("t4_a_c%0d", k), op_a1, 32'h8000_0000);
      check($sformatf("t4_b_c%0d", k), op_b1,
            ((k / 2) == 5 || (k / 2) == 6 || (k / 2) == 9) ? 32'h1F : 32'h1);
      check($sformatf("t4_done_c%0d", k), {31'h0, done1}, 32'h0);
      tick(1);
    end
    check("t4_done", {31'h0, done1}, 32'h1);
    check("t4_pass", {31'h0, pass1}, 32'h1);
    check("t4_fcnt", {16'h0, fail_count1}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Hardware built-in self-test initiator for the RV32I ALU. It drives the ALU operand and opcode inputs, captures `o_alu_data` and `Zero`, and checks them against an internal golden model.
- Sits beside the ALU in the single-cycle core and shares its combinational interface through a test mux owned by the top level.
- Reports pass/fail plus the first failing operation and vector index.

Parameters:
- VECTORS_PER_OP, 10, vectors applied per opcode (1..65535).
- SEED, 32'hACE1_2345, LFSR reload value on start; must be nonzero.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset
- i_start  input  1  start pulse; sampled only in IDLE or DONE
- o_operand_a  output  32  ALU operand A
- o_operand_b  output  32  ALU operand B
- o_alu_op  output  4  ALU opcode
- i_alu_data  input  32  ALU result
- i_zero  input  1  ALU Zero flag
- o_busy  output  1  high in APPLY/COMPARE
- o_done  output  1  high in DONE
- o_pass  output  1  valid when o_done; 1 = no mismatch
- o_fail_count  output  16  mismatching vectors, saturating at 16'hFFFF
- o_first_fail_op  output  4  opcode of first mismatch
- o_first_fail_vec  output  16  vector index within op of first mismatch

Behaviour:
- Reset:
  - One clock; reset is synchronous, active-high, on i_rst; it dominates i_start.
  - All outputs are 0 and state = IDLE.
  - Reset mid-run aborts immediately; no partial result is retained.
- Opcode map (golden model):
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 srl, 0111 sltu (unsigned), 1000 slt (signed), 1001 sra.
  - Shifts use b[4:0]. sltu/slt return 32'h1 or 32'h0.
  - Expected zero = (expected result == 32'h0).
  - Ops run in ascending order 0000..1001; total N = 10*VECTORS_PER_OP.
- FSM states: IDLE, APPLY, COMPARE, DONE.
  - IDLE --i_start--> APPLY. On this edge: LFSR <= SEED, counters cleared, fail stats cleared, vector 0 of op 0000 loaded.
  - APPLY -> COMPARE. On this edge: i_alu_data and i_zero are captured into registers.
  - COMPARE -> APPLY if vectors remain; on this edge the compare result is recorded and the next vector is loaded.
  - COMPARE -> DONE after the last vector of op 1001; on this edge the compare result is recorded.
  - DONE --i_start--> APPLY, a full restart identical to the IDLE start.
  - DONE with no i_start: hold all results.
  - i_start in APPLY/COMPARE is ignored.
- Timing: o_done first high exactly 2*N clock edges after the edge that sampled i_start. With the default, 200 cycles.
- Vector generation:
  - Vector index 0 of every op is a corner vector: a = 32'h8000_0000; b = 32'h0000_001F for shifts, else b = 32'h0000_0001.
  - Vectors 1..V-1: a = L, b = step(L), LFSR <= step(step(L)). L is the current LFSR value.
  - step is a Galois LFSR, right shift, XOR mask 32'h8020_0003 when the shifted-out bit is 1.
  - For shift ops, b is masked with 32'h1F before driving.
  - The LFSR is not reset between ops.
- Mismatch definition: (captured data != expected) OR (captured zero != expected zero).
  - On a mismatch, o_fail_count increments with saturation.
  - On the first mismatch only, o_first_fail_op and o_first_fail_vec latch.
- o_pass = (o_fail_count == 0), registered on entry to DONE. It is 0 outside DONE.
- Counter widths: vector index is 16 bits; wrap-around is impossible because VECTORS_PER_OP ≤ 65535.
- Output stability: operands and opcode are registered and stable across APPLY and COMPARE. They hold their last values in DONE and are 0 in IDLE.

Test Plan:
1. Correct ALU model, V=10, i_start pulse -> o_busy for 200 cycles; then o_done=1, o_pass=1, o_fail_count=0.
2. ALU with sra implemented as srl -> first mismatch at op 1001, vec 0 (expect 32'hFFFF_FFFF, got 32'h1). o_first_fail_op=4'b1001, o_first_fail_vec=0, o_pass=0.
3. Zero stuck at 0 -> first fail at op 0010, vec 0 (a & b = 0), o_first_fail_op=4'b0010, o_fail_count ≥ 1.
4. V=1 -> o_done 20 edges after start. Opcode sequence 0..9 is observed on o_alu_op, each held for 2 cycles with corner operands.
5. i_start re-pulsed at cycle 50 of a run -> ignored, done still at cycle 200. Then i_start in DONE -> fresh run with an identical operand stream (same SEED).
6. i_rst asserted at cycle 77 together with i_start -> next cycle IDLE, all outputs 0, o_busy=0. A later i_start gives a full 200-cycle run.
